video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/video_timing_gen_wrap_counter.sv | 31 +++
 rtl/video_timing_gen.sv | 102 ++++++++++
 tb/tb_video_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Defaults describe standard 640x480 VGA; the helpers turn per-axis
// region sizes into totals and sync-window bounds.
package video_timing_pkg;

  localparam int VGA_CW   = 11;
  localparam int VGA_HACT = 640;
  localparam int VGA_HFP  = 16;
  localparam int VGA_HSW  = 96;
  localparam int VGA_HBP  = 48;
  localparam int VGA_VACT = 480;
  localparam int VGA_VFP  = 10;
  localparam int VGA_VSW  = 2;
  localparam int VGA_VBP  = 33;
  localparam bit VGA_HS_POL = 1'b0;
  localparam bit VGA_VS_POL = 1'b0;
  localparam int VGA_FCW  = 8;

  // Raster position at the default counter width.
  typedef logic [VGA_CW-1:0] pos_t;

  // Total ticks (or lines) in one period of an axis.
  function automatic int span_total(int act, int fp, int sw, int bp);
    return act + fp + sw + bp;
  endfunction

  // First position inside the sync pulse.
  function automatic int sync_first(int act, int fp);
    return act + fp;
  endfunction

  // Last position inside the sync pulse.
  function automatic int sync_last(int act, int fp, int sw);
    return act + fp + sw - 1;
  endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous reset, synchronous clear and
// enable. at_max flags the terminal count so a following stage can cascade.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);

  localparam logic [W-1:0] QMAX = W'(MAX);

  assign at_max = (q == QMAX);

  // Count with priority reset > clear > enable; wrap to zero after MAX.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical position counters plus
// decoded sync, blanking, boundary strobes, line compare and a
// completed-frame counter. Only hc, vc and frame_cnt are registered;
// everything else is decoded from them with zero latency.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW     = VGA_CW,
  parameter int HACT   = VGA_HACT,
  parameter int HFP    = VGA_HFP,
  parameter int HSW    = VGA_HSW,
  parameter int HBP    = VGA_HBP,
  parameter int VACT   = VGA_VACT,
  parameter int VFP    = VGA_VFP,
  parameter int VSW    = VGA_VSW,
  parameter int VBP    = VGA_VBP,
  parameter bit HS_POL = VGA_HS_POL,
  parameter bit VS_POL = VGA_VS_POL,
  parameter int FCW    = VGA_FCW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic           sync_clr,
  input  logic [CW-1:0]  line_cmp,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           line_end,
  output logic           frame_start,
  output logic           frame_end,
  output logic           line_match,
  output logic [FCW-1:0] frame_cnt
);

  localparam int HTOTAL = span_total(HACT, HFP, HSW, HBP);
  localparam int VTOTAL = span_total(VACT, VFP, VSW, VBP);

  // The counters must be able to represent their terminal values.
  if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW)) begin : g_cw_check
    $error("video_timing_gen: CW=%0d cannot hold HTOTAL-1=%0d / VTOTAL-1=%0d",
           CW, HTOTAL - 1, VTOTAL - 1);
  end

  localparam logic [CW-1:0] HACT_C  = CW'(HACT);
  localparam logic [CW-1:0] VACT_C  = CW'(VACT);
  localparam logic [CW-1:0] HS_LO   = CW'(sync_first(HACT, HFP));
  localparam logic [CW-1:0] HS_HI   = CW'(sync_last(HACT, HFP, HSW));
  localparam logic [CW-1:0] VS_LO   = CW'(sync_first(VACT, VFP));
  localparam logic [CW-1:0] VS_HI   = CW'(sync_last(VACT, VFP, VSW));

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          h_at_max;
  logic          v_at_max;

  // Pixel column: advances on every tick.
  wrap_counter #(.MAX(HTOTAL - 1), .W(CW)) u_hcnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (sync_clr),
    .en     (inc),
    .q      (hc),
    .at_max (h_at_max)
  );

  // Line number: advances on the tick that ends a line.
  wrap_counter #(.MAX(VTOTAL - 1), .W(CW)) u_vcnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (sync_clr),
    .en     (inc & h_at_max),
    .q      (vc),
    .at_max (v_at_max)
  );

  // Count completed frames; a raster restart in the same cycle wins and
  // leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (!sync_clr && inc && frame_end) begin
      frame_cnt <= frame_cnt + FCW'(1);
    end
  end

  assign hcount      = hc;
  assign vcount      = vc;
  assign hsync       = (hc >= HS_LO && hc <= HS_HI) ? HS_POL : ~HS_POL;
  assign vsync       = (vc >= VS_LO && vc <= VS_HI) ? VS_POL : ~VS_POL;
  assign video_on    = (hc < HACT_C) && (vc < VACT_C);
  assign line_start  = (hc == '0);
  assign line_end    = h_at_max;
  assign frame_start = (hc == '0) && (vc == '0);
  assign frame_end   = h_at_max && v_at_max;
  // Values of line_cmp beyond the last line never equal vc, so no match.
  assign line_match  = (vc == line_cmp) && (hc == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Four instances share one stimulus stream:
// small 8x6 raster, the same with inverted polarity and FCW=2, VGA-width
// lines with a 7-line frame, and the default 640x480 VGA. A tick-count
// model derives every output from raster arithmetic and is compared on
// every cycle; directed checks pin specific positions and counts.
module tb_video_timing_gen;

  typedef struct {
    int hact, hfp, hsw, hbp;
    int vact, vfp, vsw, vbp;
    bit hpol, vpol;
    int fcw;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset, inc, sync_clr;
  logic [10:0] line_cmp;

  logic [10:0] hc [4];
  logic [10:0] vc [4];
  logic        hs [4], vs [4], von [4], ls [4], le [4], fs [4], fe [4], lm [4];
  logic [7:0]  fc_s, fc_vh, fc_v;
  logic [1:0]  fc_p;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  video_timing_gen #(.HACT(4), .HFP(1), .HSW(2), .HBP(1),
                     .VACT(3), .VFP(1), .VSW(1), .VBP(1)) dut_s (
    .clk(clk), .reset(reset), .inc(inc), .sync_clr(sync_clr), .line_cmp(line_cmp),
    .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
    .line_start(ls[0]), .line_end(le[0]), .frame_start(fs[0]), .frame_end(fe[0]),
    .line_match(lm[0]), .frame_cnt(fc_s));

  video_timing_gen #(.HACT(4), .HFP(1), .HSW(2), .HBP(1),
                     .VACT(3), .VFP(1), .VSW(1), .VBP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .FCW(2)) dut_p (
    .clk(clk), .reset(reset), .inc(inc), .sync_clr(sync_clr), .line_cmp(line_cmp),
    .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
    .line_start(ls[1]), .line_end(le[1]), .frame_start(fs[1]), .frame_end(fe[1]),
    .line_match(lm[1]), .frame_cnt(fc_p));

  video_timing_gen #(.VACT(3), .VFP(1), .VSW(2), .VBP(1)) dut_vh (
    .clk(clk), .reset(reset), .inc(inc), .sync_clr(sync_clr), .line_cmp(line_cmp),
    .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]),
    .line_start(ls[2]), .line_end(le[2]), .frame_start(fs[2]), .frame_end(fe[2]),
    .line_match(lm[2]), .frame_cnt(fc_vh));

  video_timing_gen dut_v (
    .clk(clk), .reset(reset), .inc(inc), .sync_clr(sync_clr), .line_cmp(line_cmp),
    .hcount(hc[3]), .vcount(vc[3]), .hsync(hs[3]), .vsync(vs[3]), .video_on(von[3]),
    .line_start(ls[3]), .line_end(le[3]), .frame_start(fs[3]), .frame_end(fe[3]),
    .line_match(lm[3]), .frame_cnt(fc_v));

  function automatic cfg_t get_cfg(int k);
    cfg_t c;
    case (k)
      0:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 8};
      1:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2};
      2:       c = '{640, 16, 96, 48, 3, 1, 2, 1, 1'b0, 1'b0, 8};
      default: c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
    endcase
    return c;
  endfunction

  function automatic logic [7:0] frame_of(int k);
    case (k)
      0:       return fc_s;
      1:       return {6'b0, fc_p};
      2:       return fc_vh;
      default: return fc_v;
    endcase
  endfunction

  function automatic logic [47:0] actual(int k);
    return {10'b0, hc[k], vc[k], hs[k], vs[k], von[k], ls[k], le[k],
            fs[k], fe[k], lm[k], frame_of(k)};
  endfunction

  // Expected outputs from the raster position (ticks since (0,0)).
  function automatic logic [47:0] expect_out(int k, int p, int f, int lcmp);
    cfg_t c;
    int ht, vt, h, v;
    logic hsv, vsv;
    c   = get_cfg(k);
    ht  = c.hact + c.hfp + c.hsw + c.hbp;
    vt  = c.vact + c.vfp + c.vsw + c.vbp;
    h   = p % ht;
    v   = p / ht;
    hsv = (h >= c.hact + c.hfp && h < c.hact + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
    vsv = (v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
    return {10'b0, 11'(h), 11'(v), hsv, vsv,
            (h < c.hact && v < c.vact), (h == 0), (h == ht - 1),
            (h == 0 && v == 0), (h == ht - 1 && v == vt - 1),
            (v == lcmp && h == 0), 8'(f)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply one set of inputs for the next rising edge; return just after it.
  task automatic step(input logic r, input logic i, input logic c);
    reset    = r;
    inc      = i;
    sync_clr = c;
    @(posedge clk);
    #2;
  endtask

  // Model state and dut_p frame-count history.
  int         pos [4];
  int         frames [4];
  bit         started = 1'b0;
  logic [1:0] prev_p = 2'd0;
  logic [1:0] seq_p [$];

  // Advance the model on each edge, compare every instance mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        cfg_t c;
        int period;
        c = get_cfg(k);
        period = (c.hact + c.hfp + c.hsw + c.hbp) * (c.vact + c.vfp + c.vsw + c.vbp);
        if (reset) begin
          pos[k] = 0;
          frames[k] = 0;
        end else if (sync_clr) begin
          pos[k] = 0;
        end else if (inc) begin
          if (pos[k] == period - 1) frames[k] = (frames[k] + 1) % (1 << c.fcw);
          pos[k] = (pos[k] + 1) % period;
        end
      end
      if (reset) started = 1'b1;
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 4; k++)
          check($sformatf("cycle_dut%0d", k), actual(k),
                expect_out(k, pos[k], frames[k], int'(line_cmp)));
        if (fc_p != prev_p) begin
          seq_p.push_back(fc_p);
          prev_p = fc_p;
        end
      end
    end
  end

  int lm_count, hs_run, hs_runs, hs_run_min, hs_run_max, vs_low;
  int exp_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; inc = 1'b0; sync_clr = 1'b0; line_cmp = 11'd2;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Reset state.
    check("rst_hcount", hc[0], 0);
    check("rst_vcount", vc[0], 0);
    check("rst_hsync", hs[0], 1);
    check("rst_vsync", vs[0], 1);
    check("rst_video_on", von[0], 1);
    check("rst_line_start", ls[0], 1);
    check("rst_frame_start", fs[0], 1);
    check("rst_line_end", le[0], 0);
    check("rst_frame_end", fe[0], 0);
    check("rst_line_match_cmp2", lm[0], 0);
    check("rst_frame_cnt", fc_s, 0);
    check("rst_hsync_pol1", hs[1], 0);
    check("rst_vga_hsync", hs[3], 1);
    line_cmp = 11'd0;
    #1;
    check("rst_line_match_cmp0", lm[0], 1);
    line_cmp = 11'd2;

    // One full small frame with inc held high.
    lm_count = 0;
    for (int i = 1; i <= 48; i++) begin
      step(1'b0, 1'b1, 1'b0);
      lm_count += int'(lm[0]);
      if (i == 3)  check("von_h3", von[0], 1);
      if (i == 4)  check("von_h4", von[0], 0);
      if (i == 5)  check("hsync_h5", hs[0], 0);
      if (i == 7)  check("hsync_h7", hs[0], 1);
      if (i == 32) check("vsync_v4", vs[0], 0);
      if (i == 40) check("vsync_v5", vs[0], 1);
      if (i == 47) begin
        check("fe_hcount", hc[0], 7);
        check("fe_vcount", vc[0], 5);
        check("fe_strobe", fe[0], 1);
        check("fe_frame_cnt", fc_s, 0);
      end
    end
    check("wrap_hcount", hc[0], 0);
    check("wrap_vcount", vc[0], 0);
    check("wrap_frame_cnt", fc_s, 1);
    check("line_match_cmp2_count", lm_count, 1);

    // Compare value beyond the last line never matches.
    line_cmp = 11'd7;
    lm_count = 0;
    repeat (48) begin
      step(1'b0, 1'b1, 1'b0);
      lm_count += int'(lm[0]);
    end
    check("line_match_cmp7_count", lm_count, 0);
    check("frame_cnt_2", fc_s, 2);

    // Alternating inc: 96 ticks = two more frames.
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      if (i == 0) check("hold_hcount", hc[0], 1);
    end
    check("toggle_frame_cnt", fc_s, 4);
    check("toggle_hcount", hc[0], 0);
    check("toggle_vcount", vc[0], 0);

    // sync_clr with inc at (6,2), then reset at (3,4).
    repeat (22) step(1'b0, 1'b1, 1'b0);
    check("pre_clr_hcount", hc[0], 6);
    check("pre_clr_vcount", vc[0], 2);
    step(1'b0, 1'b1, 1'b1);
    check("clr_hcount", hc[0], 0);
    check("clr_vcount", vc[0], 0);
    check("clr_frame_cnt", fc_s, 4);
    repeat (35) step(1'b0, 1'b1, 1'b0);
    check("pre_rst_hcount", hc[0], 3);
    check("pre_rst_vcount", vc[0], 4);
    step(1'b1, 1'b1, 1'b0);
    check("mid_rst_hcount", hc[0], 0);
    check("mid_rst_vcount", vc[0], 0);
    check("mid_rst_frame_cnt", fc_s, 0);

    // One VGA-width frame of 7 lines: measure sync pulse widths.
    hs_run = 0; hs_runs = 0; hs_run_min = 1 << 30; hs_run_max = 0; vs_low = 0;
    repeat (5600) begin
      step(1'b0, 1'b1, 1'b0);
      if (!hs[2]) begin
        hs_run++;
      end else if (hs_run > 0) begin
        hs_runs++;
        if (hs_run < hs_run_min) hs_run_min = hs_run;
        if (hs_run > hs_run_max) hs_run_max = hs_run;
        hs_run = 0;
      end
      vs_low += int'(!vs[2]);
    end
    check("vga_hsync_runs", hs_runs, 7);
    check("vga_hsync_min_width", hs_run_min, 96);
    check("vga_hsync_max_width", hs_run_max, 96);
    check("vga_vsync_low_ticks", vs_low, 1600);
    check("vga_frame_cnt", fc_vh, 1);
    check("vga_hcount", hc[2], 0);
    check("vga_vcount", vc[2], 0);

    // FCW=2 frame counter history.
    check("fcw2_seq_len_ok", seq_p.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (seq_p.size() > i) check($sformatf("fcw2_seq_%0d", i), seq_p[i], exp_seq[i]);

    step(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
